evaluator: RTL and testbench



---
 rtl/evaluator_pkg.sv | 40 ++++
 rtl/evaluator_if.sv | 19 +
 rtl/evaluator_eval_window.sv | 53 +++++
 rtl/evaluator.sv | 129 ++++++++++++
 tb/tb_evaluator.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/evaluator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// evaluator_pkg
// Shared board geometry, score type and heuristic weights for the
// Connect-Four board evaluator.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package evaluator_pkg;

   localparam int FIELD_W    = 7;
   localparam int FIELD_H    = 6;
   localparam int FIELD_SIZE = FIELD_W * FIELD_H;
   localparam int SCORE_W    = 16;

   typedef logic signed [SCORE_W-1:0] score_t;

   localparam score_t W1     = score_t'(1);
   localparam score_t W2     = score_t'(5);
   localparam score_t W3     = score_t'(50);
   localparam score_t WIN    = score_t'(10000);
   localparam score_t CENTER = score_t'(3);

   // Window counts per direction and their base offsets in the flat window list
   localparam int NUM_H   = FIELD_H * (FIELD_W - 3);
   localparam int NUM_V   = (FIELD_H - 3) * FIELD_W;
   localparam int NUM_D   = (FIELD_H - 3) * (FIELD_W - 3);
   localparam int BASE_V  = NUM_H;
   localparam int BASE_UR = BASE_V + NUM_V;
   localparam int BASE_UL = BASE_UR + NUM_D;
   localparam int NUM_WIN = BASE_UL + NUM_D;

   localparam int CENTER_COL = FIELD_W / 2;

   // Bit index of cell (row, col); row 0 is the bottom row
   function automatic int cell_idx(input int row, input int col);
      return row * FIELD_W + col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/evaluator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// evaluator_if
// Board-in / score-out bundle between the search controller and the
// evaluator.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface evaluator_if;
   import evaluator_pkg::*;

   logic [FIELD_SIZE-1:0] i_me_field;
   logic [FIELD_SIZE-1:0] i_opposite_field;
   score_t                o_score;

   modport master (output i_me_field, output i_opposite_field, input o_score);
   modport slave  (input i_me_field, input i_opposite_field, output o_score);

endinterface
`default_nettype wire

// File: rtl/evaluator_eval_window.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eval_window
// Scores a single length-4 line from the two sides' (already masked) bits
// and flags complete fours.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module eval_window
   import evaluator_pkg::*;
(
   input  wire logic [3:0] i_me_bits,
   input  wire logic [3:0] i_opp_bits,
   output score_t          o_score,
   output logic            o_me_four,
   output logic            o_opp_four
);

   logic [2:0] w_me_cnt;
   logic [2:0] w_opp_cnt;

   // Population counts of each side within the window
   always_comb begin
      w_me_cnt  = {2'b00, i_me_bits[0]} + {2'b00, i_me_bits[1]}
                + {2'b00, i_me_bits[2]} + {2'b00, i_me_bits[3]};
      w_opp_cnt = {2'b00, i_opp_bits[0]} + {2'b00, i_opp_bits[1]}
                + {2'b00, i_opp_bits[2]} + {2'b00, i_opp_bits[3]};
   end

   // Only uncontested windows contribute; fours are handled by the win override
   always_comb begin
      o_score = '0;
      if (w_opp_cnt == 3'd0) begin
         case (w_me_cnt)
            3'd1:    o_score = W1;
            3'd2:    o_score = W2;
            3'd3:    o_score = W3;
            default: o_score = '0;
         endcase
      end else if (w_me_cnt == 3'd0) begin
         case (w_opp_cnt)
            3'd1:    o_score = -W1;
            3'd2:    o_score = -W2;
            3'd3:    o_score = -W3;
            default: o_score = '0;
         endcase
      end
   end

   assign o_me_four  = &i_me_bits;
   assign o_opp_four = &i_opp_bits;

endmodule
`default_nettype wire

// File: rtl/evaluator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// evaluator
// Connect-Four heuristic board scorer: overlap masking, 69 window scorers,
// adder tree, win override and a single output register (1-cycle latency).
// Optional macro EVAL_CENTER_BONUS_EN adds a column-3 occupancy bonus.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module evaluator
   import evaluator_pkg::*;
(
   input  wire logic    i_clk,
   input  wire logic    i_rst,
   evaluator_if.slave   bus
);

   logic [FIELD_SIZE-1:0] w_me;
   logic [FIELD_SIZE-1:0] w_opp;
   score_t                w_win_score [NUM_WIN];
   logic [NUM_WIN-1:0]    w_me_four;
   logic [NUM_WIN-1:0]    w_opp_four;
   score_t                w_sum;
   score_t                w_center;
   score_t                w_next_score;
   score_t                r_score;

   // A cell claimed by both sides is treated as empty
   assign w_me  = bus.i_me_field & ~bus.i_opposite_field;
   assign w_opp = bus.i_opposite_field & ~bus.i_me_field;

   // Horizontal windows
   for (genvar r = 0; r < FIELD_H; r++) begin : g_h_row
      for (genvar c = 0; c <= FIELD_W - 4; c++) begin : g_h_col
         localparam int IDX = r * (FIELD_W - 3) + c;
         eval_window u_win (
            .i_me_bits  ({w_me[cell_idx(r, c+3)], w_me[cell_idx(r, c+2)],
                          w_me[cell_idx(r, c+1)], w_me[cell_idx(r, c)]}),
            .i_opp_bits ({w_opp[cell_idx(r, c+3)], w_opp[cell_idx(r, c+2)],
                          w_opp[cell_idx(r, c+1)], w_opp[cell_idx(r, c)]}),
            .o_score    (w_win_score[IDX]),
            .o_me_four  (w_me_four[IDX]),
            .o_opp_four (w_opp_four[IDX])
         );
      end
   end

   // Vertical windows
   for (genvar r = 0; r <= FIELD_H - 4; r++) begin : g_v_row
      for (genvar c = 0; c < FIELD_W; c++) begin : g_v_col
         localparam int IDX = BASE_V + r * FIELD_W + c;
         eval_window u_win (
            .i_me_bits  ({w_me[cell_idx(r+3, c)], w_me[cell_idx(r+2, c)],
                          w_me[cell_idx(r+1, c)], w_me[cell_idx(r, c)]}),
            .i_opp_bits ({w_opp[cell_idx(r+3, c)], w_opp[cell_idx(r+2, c)],
                          w_opp[cell_idx(r+1, c)], w_opp[cell_idx(r, c)]}),
            .o_score    (w_win_score[IDX]),
            .o_me_four  (w_me_four[IDX]),
            .o_opp_four (w_opp_four[IDX])
         );
      end
   end

   // Diagonal windows: up-right from (r,c) and up-left from (r,c+3)
   for (genvar r = 0; r <= FIELD_H - 4; r++) begin : g_d_row
      for (genvar c = 0; c <= FIELD_W - 4; c++) begin : g_d_col
         localparam int IDX_UR = BASE_UR + r * (FIELD_W - 3) + c;
         localparam int IDX_UL = BASE_UL + r * (FIELD_W - 3) + c;
         eval_window u_win_ur (
            .i_me_bits  ({w_me[cell_idx(r+3, c+3)], w_me[cell_idx(r+2, c+2)],
                          w_me[cell_idx(r+1, c+1)], w_me[cell_idx(r, c)]}),
            .i_opp_bits ({w_opp[cell_idx(r+3, c+3)], w_opp[cell_idx(r+2, c+2)],
                          w_opp[cell_idx(r+1, c+1)], w_opp[cell_idx(r, c)]}),
            .o_score    (w_win_score[IDX_UR]),
            .o_me_four  (w_me_four[IDX_UR]),
            .o_opp_four (w_opp_four[IDX_UR])
         );
         eval_window u_win_ul (
            .i_me_bits  ({w_me[cell_idx(r+3, c)], w_me[cell_idx(r+2, c+1)],
                          w_me[cell_idx(r+1, c+2)], w_me[cell_idx(r, c+3)]}),
            .i_opp_bits ({w_opp[cell_idx(r+3, c)], w_opp[cell_idx(r+2, c+1)],
                          w_opp[cell_idx(r+1, c+2)], w_opp[cell_idx(r, c+3)]}),
            .o_score    (w_win_score[IDX_UL]),
            .o_me_four  (w_me_four[IDX_UL]),
            .o_opp_four (w_opp_four[IDX_UL])
         );
      end
   end

   // Sum of all window scores (magnitude bounded well inside 16 bits)
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NUM_WIN; i++) begin
         w_sum = w_sum + w_win_score[i];
      end
   end

`ifdef EVAL_CENTER_BONUS_EN
   // Centre-column occupancy bonus
   always_comb begin
      w_center = '0;
      for (int r = 0; r < FIELD_H; r++) begin
         if (w_me[cell_idx(r, CENTER_COL)]) w_center = w_center + CENTER;
         if (w_opp[cell_idx(r, CENTER_COL)]) w_center = w_center - CENTER;
      end
   end
`else
   assign w_center = '0;
`endif

   // Win override takes precedence over the heuristic sum
   always_comb begin
      case ({|w_me_four, |w_opp_four})
         2'b10:   w_next_score = WIN;
         2'b01:   w_next_score = -WIN;
         2'b11:   w_next_score = '0;
         default: w_next_score = w_sum + w_center;
      endcase
   end

   // Output register with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) r_score <= '0;
      else       r_score <= w_next_score;
   end

   assign bus.o_score = r_score;

endmodule
`default_nettype wire

// File: tb/tb_evaluator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_evaluator
// Scoreboard bench for the evaluator: stimulus pushes expected scores,
// a monitor pops and compares one cycle after each issued input.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_evaluator;
   import evaluator_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic issued = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   exp_q [$];
   string name_q [$];

   evaluator_if bus ();

   evaluator dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: walk every line of four directly on the board geometry
   function automatic int model(input logic [41:0] me_in, input logic [41:0] opp_in);
      logic [41:0] m;
      logic [41:0] o;
      int dr [4];
      int dc [4];
      int wt [4];
      int sum;
      int nm;
      int np;
      int rr;
      int cc;
      bit me_win;
      bit opp_win;
      m = me_in & ~opp_in;
      o = opp_in & ~me_in;
      dr = '{0, 1, 1, 1};
      dc = '{1, 0, 1, -1};
      wt = '{0, 1, 5, 50};
      sum = 0;
      me_win = 0;
      opp_win = 0;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 7; c++) begin
            for (int d = 0; d < 4; d++) begin
               rr = r + 3 * dr[d];
               cc = c + 3 * dc[d];
               if (rr < 6 && cc >= 0 && cc < 7) begin
                  nm = 0;
                  np = 0;
                  for (int k = 0; k < 4; k++) begin
                     nm += int'(m[(r + k * dr[d]) * 7 + c + k * dc[d]]);
                     np += int'(o[(r + k * dr[d]) * 7 + c + k * dc[d]]);
                  end
                  if (nm == 4) me_win = 1;
                  if (np == 4) opp_win = 1;
                  if (np == 0 && nm < 4) sum += wt[nm];
                  if (nm == 0 && np < 4) sum -= wt[np];
               end
            end
         end
      end
      if (me_win && opp_win) return 0;
      if (me_win) return 10000;
      if (opp_win) return -10000;
`ifdef EVAL_CENTER_BONUS_EN
      for (int r = 0; r < 6; r++) begin
         if (m[r * 7 + 3]) sum += 3;
         if (o[r * 7 + 3]) sum -= 3;
      end
`endif
      return sum;
   endfunction

   // Present one input set for one cycle and record its expected result
   task automatic issue(input logic r, input logic [41:0] me_f, input logic [41:0] opp_f,
                        input int exp_v, input string nm);
      @(negedge clk);
      rst = r;
      bus.i_me_field = me_f;
      bus.i_opposite_field = opp_f;
      issued = 1'b1;
      exp_q.push_back(exp_v);
      name_q.push_back(nm);
   endtask

   // Monitor: result of inputs sampled at an edge is checked just after it
   initial begin
      bit    v;
      int    e;
      string n;
      forever begin
         @(posedge clk);
         v = issued;
         #1;
         if (v) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_underflow: got %0d, nothing expected", $signed(bus.o_score));
            end else begin
               e = exp_q.pop_front();
               n = name_q.pop_front();
               if (int'($signed(bus.o_score)) != e) begin
                  errors++;
                  $display("FAIL %s: got %0d, expected %0d", n, $signed(bus.o_score), e);
               end
            end
         end
      end
   end

   initial begin
      logic [41:0] a;
      logic [41:0] b;
      int bonus;
`ifdef EVAL_CENTER_BONUS_EN
      bonus = 3;
`else
      bonus = 0;
`endif
      bus.i_me_field = '0;
      bus.i_opposite_field = '0;

      // Reset held with arbitrary boards
      for (int i = 0; i < 3; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         issue(1'b1, a, b, 0, "reset");
      end

      issue(1'b0, 42'd0, 42'd0, 0, "empty");
      issue(1'b0, 42'd1, 42'd0, 3, "me_bit0");
      issue(1'b0, 42'd0, 42'd1, -3, "opp_bit0");
      issue(1'b0, 42'd1 << 3, 42'd0, 7 + bonus, "me_center");
      issue(1'b0, 42'h00F, 42'd0, 10000, "me_row_win");
      a = (42'd1 << 3) | (42'd1 << 10) | (42'd1 << 17) | (42'd1 << 24);
      issue(1'b0, 42'd0, a, -10000, "opp_col_win");
      b = 42'h00F << 35;
      issue(1'b0, b, a, 0, "both_win");
      issue(1'b0, 42'd1 | (42'd1 << 20), 42'd1 << 20, 3, "overlap");
      issue(1'b0, 42'h00F, 42'h00F, 0, "overlap_full");
      issue(1'b1, 42'h00F, 42'd0, 0, "reset_mid");

      // Randomized back-to-back boards of varying density
      for (int i = 0; i < 400; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case (i % 4)
            0: begin a &= {$urandom, $urandom} & {$urandom, $urandom}; b &= {$urandom, $urandom} & {$urandom, $urandom}; end
            1: begin a &= {$urandom, $urandom}; b &= {$urandom, $urandom} & {$urandom, $urandom}; end
            2: begin a &= {$urandom, $urandom} & {$urandom, $urandom}; b &= {$urandom, $urandom}; end
            default: ;
         endcase
         issue(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, a, b, 0, "random");
         if (rst) exp_q[exp_q.size() - 1] = 0;
         else     exp_q[exp_q.size() - 1] = model(a, b);
      end

      @(negedge clk);
      issued = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
